// File: rtl/alien_bomb.sv
`default_nettype none
// ============================================================================
// Module   : alien_bomb
// Purpose  : Alien return fire. Drops one bomb from the lowest live alien of a
//            pseudo-random column, moves it down the screen and scores ship hits.
// Revision : 1.0 - initial release
// ============================================================================
module alien_bomb #(
    parameter int         NB_LIN      = 2,
    parameter int         NB_COL      = 2,
    parameter int         PITCH_X     = 40,
    parameter int         PITCH_Y     = 40,
    parameter int         ALIEN_W     = 20,
    parameter int         ALIEN_H     = 16,
    parameter int         BOMB_W      = 2,
    parameter int         BOMB_H      = 6,
    parameter int         BOMB_SPEED  = 2,
    parameter int         COOLDOWN    = 4,
    parameter int         SHIP_Y      = 440,
    parameter int         SHIP_H      = 16,
    parameter int         SHIP_HALF_W = 12,
    parameter int         SCREEN_W    = 640,
    parameter int         SCREEN_H    = 480,
    parameter logic [2:0] BOMB_COLOR  = 3'b100,
    parameter int         LIVES       = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     gameOver,
    input  logic signed [10:0]       xAlien,
    input  logic        [9:0]        yAlien,
    input  logic [NB_LIN*NB_COL-1:0] alive,
    input  logic        [9:0]        gunPosition,
    input  logic        [9:0]        hPos,
    input  logic        [9:0]        vPos,
    output logic        [9:0]        xBomb,
    output logic        [9:0]        yBomb,
    output logic                     bombActive,
    output logic                     shipHit,
    output logic        [1:0]        lives,
    output logic                     dead,
    output logic        [2:0]        colorBomb
);

    localparam int COL_W = (NB_COL > 1) ? $clog2(NB_COL) : 1;
    localparam int LIN_W = (NB_LIN > 1) ? $clog2(NB_LIN) : 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SELECT  = 2'd1,
        S_FALLING = 2'd2,
        S_HIT     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [COL_W-1:0]  scan_q, scan_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [9:0]        x_bomb_q, x_bomb_d;
    logic [9:0]        y_bomb_q, y_bomb_d;
    logic              active_q, active_d;
    logic              hit_q, hit_d;
    logic [1:0]        lives_q, lives_d;
    logic              dead_q, dead_d;

    logic [NB_COL-1:0] w_row_bits;
    logic              w_col_found;
    logic [LIN_W-1:0]  w_col_lin;
    logic [11:0]       w_spawn_x;
    logic [9:0]        w_spawn_y;
    logic              w_spawn_ok;
    logic [10:0]       w_x_ext, w_y_ext, w_gun_ext, w_h_ext, w_v_ext, w_ship_left;
    logic              w_overlap, w_off_screen;

    // Candidate bomb for the column currently being examined
    always_comb begin
        w_row_bits  = '0;
        w_col_found = 1'b0;
        w_col_lin   = '0;
        for (int l = 0; l < NB_LIN; l++) begin
            w_row_bits = alive[l*NB_COL +: NB_COL];
            if (w_row_bits[col_q]) begin
                w_col_found = 1'b1;
                w_col_lin   = LIN_W'(l);
            end
        end
        w_spawn_x  = {xAlien[10], xAlien} + 12'(int'(col_q) * PITCH_X)
                   + 12'(ALIEN_W / 2 - BOMB_W / 2);
        w_spawn_y  = yAlien + 10'(int'(w_col_lin) * PITCH_Y) + 10'(ALIEN_H);
        w_spawn_ok = w_col_found && !w_spawn_x[11]
                   && (w_spawn_x[10:0] <= 11'(SCREEN_W - BOMB_W));
    end

    assign w_x_ext     = {1'b0, x_bomb_q};
    assign w_y_ext     = {1'b0, y_bomb_q};
    assign w_gun_ext   = {1'b0, gunPosition};
    assign w_h_ext     = {1'b0, hPos};
    assign w_v_ext     = {1'b0, vPos};
    assign w_ship_left = (w_gun_ext >= 11'(SHIP_HALF_W)) ? w_gun_ext - 11'(SHIP_HALF_W) : '0;

    assign w_overlap = (w_y_ext + 11'(BOMB_H) > 11'(SHIP_Y))
                    && (w_y_ext < 11'(SHIP_Y + SHIP_H))
                    && (w_x_ext + 11'(BOMB_W) > w_ship_left)
                    && (w_x_ext < w_gun_ext + 11'(SHIP_HALF_W + 1));
    assign w_off_screen = (w_y_ext >= 11'(SCREEN_H));

    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        col_d    = col_q;
        scan_d   = scan_q;
        x_bomb_d = x_bomb_q;
        y_bomb_d = y_bomb_q;
        active_d = active_q;
        hit_d    = 1'b0;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        lives_d  = lives_q;
        if (hit_q) begin
            lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
        end
        dead_d = (lives_d == 2'd0);

        case (state_q)
            S_IDLE: begin
                if (!(dead_q || gameOver)) begin
                    if (cd_q == '0) begin
                        col_d   = COL_W'(int'(lfsr_q) % NB_COL);
                        scan_d  = '0;
                        state_d = S_SELECT;
                    end else if (enable) begin
                        cd_d = cd_q - 1'b1;
                    end
                end
            end
            S_SELECT: begin
                if (w_spawn_ok) begin
                    x_bomb_d = w_spawn_x[9:0];
                    y_bomb_d = w_spawn_y;
                    active_d = 1'b1;
                    state_d  = S_FALLING;
                end else if (int'(scan_q) == NB_COL - 1) begin
                    cd_d    = CD_W'(COOLDOWN);
                    state_d = S_IDLE;
                end else begin
                    scan_d = scan_q + 1'b1;
                    col_d  = (int'(col_q) == NB_COL - 1) ? '0 : col_q + 1'b1;
                end
            end
            S_FALLING: begin
                if (w_overlap) begin
                    state_d = S_HIT;
                end else if (w_off_screen) begin
                    active_d = 1'b0;
                    cd_d     = CD_W'(COOLDOWN);
                    state_d  = S_IDLE;
                end else if (enable) begin
                    y_bomb_d = y_bomb_q + 10'(BOMB_SPEED);
                end
            end
            S_HIT: begin
                hit_d    = 1'b1;
                active_d = 1'b0;
                cd_d     = CD_W'(COOLDOWN);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Game over aborts any bomb in flight and suppresses a pending hit
        if (gameOver) begin
            state_d  = S_IDLE;
            active_d = 1'b0;
            hit_d    = 1'b0;
            if (state_q != S_IDLE) begin
                cd_d = CD_W'(COOLDOWN);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cd_q     <= CD_W'(COOLDOWN);
            col_q    <= '0;
            scan_q   <= '0;
            lfsr_q   <= 8'hA5;
            x_bomb_q <= '0;
            y_bomb_q <= '0;
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            lives_q  <= 2'(LIVES);
            dead_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            col_q    <= col_d;
            scan_q   <= scan_d;
            lfsr_q   <= lfsr_d;
            x_bomb_q <= x_bomb_d;
            y_bomb_q <= y_bomb_d;
            active_q <= active_d;
            hit_q    <= hit_d;
            lives_q  <= lives_d;
            dead_q   <= dead_d;
        end
    end

    always_comb begin
        colorBomb = '0;
        if (active_q
            && (w_h_ext >= w_x_ext) && (w_h_ext < w_x_ext + 11'(BOMB_W))
            && (w_v_ext >= w_y_ext) && (w_v_ext < w_y_ext + 11'(BOMB_H))) begin
            colorBomb = BOMB_COLOR;
        end
    end

    assign xBomb      = x_bomb_q;
    assign yBomb      = y_bomb_q;
    assign bombActive = active_q;
    assign shipHit    = hit_q;
    assign lives      = lives_q;
    assign dead       = dead_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_bomb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alien_bomb
// Purpose  : Self-checking bench for alien_bomb (spawn table, fall, hit, miss).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alien_bomb;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               gameOver = 1'b0;
    logic signed [10:0] xAlien = '0;
    logic        [9:0]  yAlien = '0;
    logic        [3:0]  alive = '0;
    logic        [9:0]  gunPosition = 10'd300;
    logic        [9:0]  hPos = '0;
    logic        [9:0]  vPos = '0;
    logic        [9:0]  xBomb, yBomb;
    logic               bombActive, shipHit, dead;
    logic        [1:0]  lives;
    logic        [2:0]  colorBomb;

    alien_bomb dut (
        .clk(clk), .reset(reset), .enable(enable), .gameOver(gameOver),
        .xAlien(xAlien), .yAlien(yAlien), .alive(alive), .gunPosition(gunPosition),
        .hPos(hPos), .vPos(vPos), .xBomb(xBomb), .yBomb(yBomb),
        .bombActive(bombActive), .shipHit(shipHit), .lives(lives), .dead(dead),
        .colorBomb(colorBomb)
    );

    always #5 clk = ~clk;

    // Expected bomb for each possible start column (x0/y0: column 0 first)
    typedef struct {
        logic [3:0] alive;
        int xa;
        int ya;
        bit valid;
        int x0;
        int y0;
        int x1;
        int y1;
    } spawn_t;

    typedef struct {
        int h;
        int v;
        int c;
    } color_t;

    spawn_t sb_q[$];
    spawn_t mon_e;
    spawn_t vecs[10];
    color_t cvecs[9];
    spawn_t base_e = '{4'b0101, 100, 50, 1'b1, 109, 106, 109, 106};

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int tick_cyc = 0;
    int hit_pulses = 0;
    int hit_hi_cycles = 0;
    logic [7:0] tb_lfsr = 8'hA5;
    logic [7:0] tick_lfsr = 8'h00;
    logic prev_active = 1'b0;
    logic prev_hit = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps every clock
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) tb_lfsr <= 8'hA5;
        else       tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
    end

    // Scoreboard side: a new bomb pops the expectation pushed by the stimulus
    always @(negedge clk) begin
        if (!reset && bombActive && !prev_active) begin
            check("spawn_expected", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("spawn_x", int'(xBomb), tick_lfsr[0] ? mon_e.x1 : mon_e.x0);
                check("spawn_y", int'(yBomb), tick_lfsr[0] ? mon_e.y1 : mon_e.y0);
                check("spawn_latency_2_to_3", int'((cyc - tick_cyc) >= 2 && (cyc - tick_cyc) <= 3), 1);
            end
        end
        if (shipHit) hit_hi_cycles++;
        if (shipHit && !prev_hit) begin
            hit_pulses++;
            check("hit_latency", cyc - tick_cyc, 2);
        end
        prev_active = bombActive;
        prev_hit    = shipHit;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; gameOver = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable    = 1'b0;
        tick_cyc  = cyc;
        tick_lfsr = tb_lfsr;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_spawn(input spawn_t e);
        repeat (3) tick();
        sb_q.push_back(e);
        tick();
        @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        check("active_after_spawn", int'(bombActive), 1);
    endtask

    task automatic fall_to(input int ticks, input int y0);
        for (int k = 1; k <= ticks; k++) begin
            tick();
            check("fall_y", int'(yBomb), y0 + 2 * k);
        end
    endtask

    task automatic apply_alien(input spawn_t e);
        alive  = e.alive;
        xAlien = 11'(e.xa);
        yAlien = 10'(e.ya);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base_hits;
        vecs[0] = '{4'b1111,  100,  50, 1'b1, 109, 106, 149, 106};
        vecs[1] = '{4'b0101,  100,  50, 1'b1, 109, 106, 109, 106};
        vecs[2] = '{4'b0010,  100,  50, 1'b1, 149,  66, 149,  66};
        vecs[3] = '{4'b0000,  100,  50, 1'b0,   0,   0,   0,   0};
        vecs[4] = '{4'b0011,   -9,  50, 1'b1,   0,  66,  40,  66};
        vecs[5] = '{4'b1111,  600,  50, 1'b1, 609, 106, 609, 106};
        vecs[6] = '{4'b1111,  -10,  50, 1'b1,  39, 106,  39, 106};
        vecs[7] = '{4'b0010,  589,  50, 1'b1, 638,  66, 638,  66};
        vecs[8] = '{4'b0010,  590,  50, 1'b0,   0,   0,   0,   0};
        vecs[9] = '{4'b0100,   20, 200, 1'b1,  29, 256,  29, 256};

        cvecs[0] = '{109, 106, 4};
        cvecs[1] = '{110, 106, 4};
        cvecs[2] = '{111, 106, 0};
        cvecs[3] = '{108, 106, 0};
        cvecs[4] = '{109, 111, 4};
        cvecs[5] = '{110, 111, 4};
        cvecs[6] = '{109, 112, 0};
        cvecs[7] = '{109, 105, 0};
        cvecs[8] = '{  0,   0, 0};

        // Reset state
        do_reset();
        check("rst_xBomb", int'(xBomb), 0);
        check("rst_yBomb", int'(yBomb), 0);
        check("rst_active", int'(bombActive), 0);
        check("rst_shipHit", int'(shipHit), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_dead", int'(dead), 0);
        check("rst_color", int'(colorBomb), 0);

        // Game over freezes everything
        apply_alien(vecs[0]);
        hPos = 10'd109; vPos = 10'd106;
        gameOver = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("gameover_active", int'(bombActive), 0);
            check("gameover_color", int'(colorBomb), 0);
        end
        check("gameover_lives", int'(lives), 3);
        gameOver = 1'b0;
        hPos = '0; vPos = '0;

        // Spawn table
        for (int i = 0; i < 10; i++) begin
            do_reset();
            apply_alien(vecs[i]);
            if (vecs[i].valid) begin
                expect_spawn(vecs[i]);
            end else begin
                repeat (4) tick();
                @(negedge clk);
                check("no_spawn_active", int'(bombActive), 0);
                apply_alien(base_e);
                repeat (3) tick();
                check("cooldown_reload_active", int'(bombActive), 0);
                sb_q.push_back(base_e);
                tick();
                @(negedge clk);
                check("recover_sb_drained", sb_q.size(), 0);
            end
        end

        // Bomb pixel colour
        do_reset();
        apply_alien(base_e);
        gunPosition = 10'd300;
        expect_spawn(base_e);
        for (int i = 0; i < 9; i++) begin
            hPos = 10'(cvecs[i].h);
            vPos = 10'(cvecs[i].v);
            #1;
            check("color", int'(colorBomb), cvecs[i].c);
        end
        hPos = '0; vPos = '0;

        // Game over in mid-fall
        fall_to(10, 106);
        @(negedge clk);
        gameOver = 1'b1;
        @(negedge clk);
        check("go_midfall_active", int'(bombActive), 0);
        check("go_midfall_lives", int'(lives), 3);
        check("go_midfall_hit", int'(shipHit), 0);
        gameOver = 1'b0;

        // Miss: bomb leaves the screen, next bomb after a full cooldown
        do_reset();
        base_hits = hit_pulses;
        expect_spawn(base_e);
        fall_to(186, 106);
        tick();
        @(negedge clk);
        check("miss_cleared", int'(bombActive), 0);
        check("miss_no_hit", hit_pulses - base_hits, 0);
        check("miss_lives", int'(lives), 3);
        expect_spawn(base_e);

        // Hit, then reset mid-fall restores lives
        gunPosition = 10'd109;
        do_reset();
        base_hits = hit_pulses;
        hit_hi_cycles = 0;
        expect_spawn(base_e);
        fall_to(164, 106);
        tick();
        @(negedge clk);
        check("hit_count", hit_pulses - base_hits, 1);
        check("hit_width", hit_hi_cycles, 1);
        check("hit_lives", int'(lives), 2);
        check("hit_dead", int'(dead), 0);
        check("hit_cleared", int'(bombActive), 0);
        expect_spawn(base_e);
        fall_to(3, 106);
        @(negedge clk);
        reset = 1'b1; enable = 1'b1;
        @(negedge clk);
        check("rst_mid_active", int'(bombActive), 0);
        check("rst_mid_yBomb", int'(yBomb), 0);
        check("rst_mid_xBomb", int'(xBomb), 0);
        check("rst_mid_lives", int'(lives), 3);
        reset = 1'b0; enable = 1'b0;

        // Run lives down to zero
        for (int h = 1; h <= 3; h++) begin
            expect_spawn(base_e);
            fall_to(164, 106);
            tick();
            @(negedge clk);
            check("lives_after_hit", int'(lives), 3 - h);
            check("dead_after_hit", int'(dead), (h == 3) ? 1 : 0);
        end
        check("total_hits", hit_pulses - base_hits, 4);
        check("total_hit_width", hit_hi_cycles, 4);
        repeat (10) tick();
        @(negedge clk);
        check("dead_no_spawn", int'(bombActive), 0);
        check("dead_held", int'(dead), 1);
        check("lives_held", int'(lives), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
